// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch queue between a synchronous instruction ROM
//                and decode. Issues at most one ROM read per cycle under a
//                credit rule, buffers {pc, instruction} pairs in a FIFO,
//                and flushes and refetches on a redirect from execute.
//  Ports       : clock        - pipeline clock, rising edge
//                reset_n      - asynchronous active-low reset
//                imem_addr    - ROM address (current fetch PC)
//                imem_q       - ROM data, one cycle after its address
//                stall        - decode cannot take the head entry
//                redirect     - flush and refetch from redirect_pc
//                redirect_pc  - new fetch target
//                decode_ir    - head instruction (NOP when empty)
//                decode_pc    - head PC (0 when empty)
//                decode_valid - head entry present
//                occupancy    - number of queued entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_q,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [31:0]   decode_ir,
    output logic [AW-1:0] decode_pc,
    output logic          decode_valid,
    output logic [3:0]    occupancy
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] C_DEPTH = 5'(DEPTH);

    logic [AW-1:0] fetch_pc_q,    fetch_pc_d;
    logic          inflight_q,    inflight_d;
    logic [AW-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [3:0]    count_q,       count_d;

    logic [AW-1:0] pc_mem_q [DEPTH];
    logic [31:0]   ir_mem_q [DEPTH];

    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_credit;

    // Head of queue drives decode directly; nothing is bypassed from imem_q.
    assign decode_valid = (count_q != 4'd0);
    assign decode_pc    = decode_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign decode_ir    = decode_valid ? ir_mem_q[rd_ptr_q] : 32'h0;
    assign occupancy    = count_q;
    assign imem_addr    = fetch_pc_q;

    // The outstanding read counts as a reserved slot, so a returning
    // instruction always finds room and the queue can never overflow.
    assign w_credit = {1'b0, count_q} + {4'd0, inflight_q};
    assign w_issue  = ~redirect & (w_credit < C_DEPTH);
    assign w_push   = ~redirect & inflight_q;
    assign w_pop    = ~redirect & decode_valid & ~stall;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            // Flush everything; the ROM word returning next cycle belongs
            // to the abandoned path and is dropped by clearing inflight.
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = 4'd0;
        end else begin
            // Any pending read completes this edge, so inflight simply
            // follows whether a new read is launched.
            inflight_d = w_issue;
            if (w_issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 1'b1;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 4'd1;
            end else if (w_pop && !w_push) begin
                count_d = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= 4'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q] <= inflight_pc_q;
            ir_mem_q[wr_ptr_q] <= imem_q;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..8).
REQ-002 The module SHALL have parameter AW, default 10, meaning the PC/instruction-ROM address width.
REQ-003 The port list SHALL be: clock  input  1  single pipeline clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr  output  AW  address to instruction ROM; equals fetch_pc.
REQ-006 imem_q  input  32  ROM data, valid one cycle after the address that produced it.
REQ-007 stall  input  1  decode cannot accept the current entry this cycle.
REQ-008 redirect  input  1  jump/taken-beq resolved in execute; flush and refetch.
REQ-009 redirect_pc  input  AW  new fetch target, sampled when redirect=1.
REQ-010 decode_ir  output  32  instruction at queue head; 32'h0 (NOP) when not valid.
REQ-011 decode_pc  output  AW  PC of head entry; 0 when not valid.
REQ-012 decode_valid  output  1  head entry present.
REQ-013 occupancy  output  4  current entry count, 0..DEPTH.

Function
REQ-014 Each entry SHALL hold {pc, instruction}; order SHALL be strict FIFO.
REQ-015 The issue condition SHALL be (occupancy + inflight) < DEPTH and redirect=0; inflight is a 1-bit flag marking an outstanding ROM read.
REQ-016 On an issuing edge, fetch_pc SHALL increment by 1 modulo 2^AW (1023 -> 0 wraps), inflight SHALL set, and the issued PC SHALL be captured as inflight_pc.
REQ-017 On an edge with inflight=1 and no redirect, {inflight_pc, imem_q} SHALL be pushed; inflight clears unless a new issue occurs on the same edge.
REQ-018 Pop SHALL occur on an edge where decode_valid=1, stall=0 and redirect=0.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order, including when occupancy=DEPTH or occupancy=1.
REQ-020 The credit rule SHALL guarantee no push into a full queue; overflow is impossible by construction.
REQ-021 Pop on an empty queue SHALL not occur (decode_valid=0); pointers SHALL be unaffected.
REQ-022 Read/write pointers SHALL be log2(DEPTH) bits and wrap naturally.
REQ-023 decode_ir, decode_pc and decode_valid SHALL be combinational from the head entry and occupancy; no bypass from imem_q.
REQ-024 Steady state with stall=0 SHALL deliver one instruction per cycle.
REQ-025 Redirect SHALL take priority over stall, push, pop and issue on the same edge.
REQ-026 On a redirect edge: occupancy SHALL become 0, pointers SHALL reset, inflight SHALL clear (the next imem_q is discarded), and fetch_pc SHALL become redirect_pc.
REQ-027 After a redirect edge, the first refetched entry SHALL be visible (decode_valid=1) after exactly 2 further rising edges, absent another redirect.
REQ-028 A stall held N cycles SHALL hold the head entry stable; the queue SHALL fill to DEPTH and issue SHALL then cease until a pop.

Reset
REQ-029 Assertion of reset_n=0 SHALL immediately force: fetch_pc=0, inflight=0, occupancy=0, pointers=0, decode_valid=0, decode_ir=0, decode_pc=0.
REQ-030 A reset asserted mid-operation SHALL discard all entries and any in-flight read; the first edge after release SHALL issue address 0.
REQ-031 After reset release, decode_valid SHALL rise after the 2nd rising edge, with decode_pc=0 and decode_ir=ROM[0].

Verification
REQ-032 Bench: ROM[i]=i+32'h100, stall=0, release reset -> decode_pc 0,1,2,... on consecutive cycles from the 2nd edge; decode_ir=32'h100,32'h101,...; occupancy stays 1.
REQ-033 Bench: stall=1 for 8 cycles from steady state -> decode_pc frozen; occupancy reaches 4; imem_addr stops advancing; release -> sequence resumes with no gap or duplicate.
REQ-034 Bench: redirect=1, redirect_pc=10'd40 while occupancy=3 and stall=1 -> occupancy=0 and decode_valid=0 on the next cycle; decode_pc=40 valid 2 edges after redirect; stale PCs are never presented.
REQ-035 Bench: preload fetch via redirect_pc=10'd1022 -> decode_pc sequence 1022, 1023, 0, 1.
REQ-036 Bench: assert reset_n=0 asynchronously between edges with occupancy=2 -> outputs zero immediately; after release, decode_pc=0 on the 2nd edge.
REQ-037 Bench: back-to-back redirects on consecutive edges (to 5, then 9) -> only PC 9 stream appears, valid 2 edges after the second redirect.
